// File: rtl/quant_ctrl.sv
// rtl/quant_ctrl.sv - per-channel requant sequencer: param fetch, config load, accumulator streaming
module quant_ctrl #(
    parameter int NCH  = 16,
    parameter int NPIX = 1024,
    parameter int CW   = 4,
    parameter int PW   = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          p_rd,
    output logic [CW-1:0] p_addr,
    input  logic [31:0]   p_qmul,
    input  logic [3:0]    p_shift,
    input  logic [31:0]   p_offset,
    output logic          q_load,
    output logic [31:0]   q_qmul,
    output logic [3:0]    q_shift,
    output logic [31:0]   q_offset,
    output logic [31:0]   q_acc,
    input  logic [31:0]   q_out,
    input  logic          acc_valid,
    output logic          acc_ready,
    input  logic [31:0]   acc_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [CW-1:0] out_ch,
    output logic          out_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_RUN, S_DRAIN, S_FIN
    } state_t;

    // Pixel counter is one bit wider than PW so a power-of-two NPIX never wraps.
    localparam logic [PW:0]   PIX_END  = (PW+1)'(NPIX);
    localparam logic [PW:0]   PIX_LAST = (PW+1)'(NPIX - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

    state_t        state, state_nx;
    logic [CW-1:0] ch;
    logic [PW:0]   pix;
    logic          stage_valid;
    logic          stage_last;
    logic          out_load;
    logic          acc_fire;
    logic          unused_q_out;

    assign unused_q_out = ^q_out[31:8];

    assign out_load  = stage_valid && (!out_valid || out_ready);
    assign acc_ready = (state == S_RUN) && (pix < PIX_END) && (!stage_valid || out_load);
    assign acc_fire  = acc_valid && acc_ready;

    assign busy   = (state != S_IDLE);
    assign p_rd   = (state == S_FETCH);
    assign p_addr = ch;
    assign q_load = (state == S_LOAD);
    assign done   = (state == S_FIN) && !out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: state_nx = S_WAIT;
            S_WAIT:  state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   if (acc_fire && pix == PIX_LAST) state_nx = S_DRAIN;
            // Next channel's config may only load once this channel has left the stage.
            S_DRAIN: if (!stage_valid) state_nx = (ch == CH_LAST) ? S_FIN : S_FETCH;
            S_FIN:   if (!out_valid) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch       <= '0;
            pix      <= '0;
            q_qmul   <= '0;
            q_shift  <= '0;
            q_offset <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                ch <= '0;
            end else if (state == S_DRAIN && !stage_valid && ch != CH_LAST) begin
                ch <= ch + CW'(1);
            end
            if (state == S_WAIT) begin
                q_qmul   <= p_qmul;
                q_shift  <= p_shift;
                q_offset <= p_offset;
            end
            if (state == S_LOAD) begin
                pix <= '0;
            end else if (acc_fire) begin
                pix <= pix + 1'b1;
            end
        end
    end

    // Stage register feeding the requant datapath; q_out is valid while stage_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_acc       <= '0;
            stage_valid <= 1'b0;
            stage_last  <= 1'b0;
        end else begin
            if (acc_fire) begin
                q_acc       <= acc_data;
                stage_valid <= 1'b1;
                stage_last  <= (pix == PIX_LAST) && (ch == CH_LAST);
            end else if (out_load) begin
                stage_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= q_out[7:0];
                out_ch    <= ch;
                out_last  <= stage_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quant_ctrl.sv
// tb/tb_quant_ctrl.sv - randomized self-checking bench for quant_ctrl
module tb_quant_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: NCH=1, NPIX=4 with tight PW; instance 1: NCH=3, NPIX=5.
    logic        start [2];
    logic        acc_valid [2];
    logic        out_ready [2];
    logic [31:0] acc_data [2];
    logic [31:0] p_qmul [2];
    logic [3:0]  p_shift [2];
    logic [31:0] p_offset [2];
    logic [31:0] q_qmul [2];
    logic [3:0]  q_shift [2];
    logic [31:0] q_offset [2];
    logic [31:0] q_acc [2];
    logic [31:0] q_out [2];
    logic        busy [2];
    logic        done [2];
    logic        p_rd [2];
    logic        q_load [2];
    logic        acc_ready [2];
    logic        out_valid [2];
    logic        out_last [2];
    logic [7:0]  out_data [2];
    logic [1:0]  p_addr [2];
    logic [1:0]  out_ch [2];

    logic [31:0] mem_qmul [2][4];
    logic [3:0]  mem_shift [2][4];
    logic [31:0] mem_offset [2][4];
    logic [31:0] cfg_qmul [2];
    logic [3:0]  cfg_shift [2];

    int tests = 0;
    int fails = 0;

    quant_ctrl #(.NCH(1), .NPIX(4), .CW(2), .PW(2)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .p_rd(p_rd[0]), .p_addr(p_addr[0]), .p_qmul(p_qmul[0]), .p_shift(p_shift[0]),
        .p_offset(p_offset[0]), .q_load(q_load[0]), .q_qmul(q_qmul[0]), .q_shift(q_shift[0]),
        .q_offset(q_offset[0]), .q_acc(q_acc[0]), .q_out(q_out[0]), .acc_valid(acc_valid[0]),
        .acc_ready(acc_ready[0]), .acc_data(acc_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ch(out_ch[0]), .out_last(out_last[0])
    );

    quant_ctrl #(.NCH(3), .NPIX(5), .CW(2), .PW(3)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .p_rd(p_rd[1]), .p_addr(p_addr[1]), .p_qmul(p_qmul[1]), .p_shift(p_shift[1]),
        .p_offset(p_offset[1]), .q_load(q_load[1]), .q_qmul(q_qmul[1]), .q_shift(q_shift[1]),
        .q_offset(q_offset[1]), .q_acc(q_acc[1]), .q_out(q_out[1]), .acc_valid(acc_valid[1]),
        .acc_ready(acc_ready[1]), .acc_data(acc_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ch(out_ch[1]), .out_last(out_last[1])
    );

    function automatic logic [31:0] requant(input logic signed [31:0] acc, input logic signed [31:0] qm,
                                            input logic [3:0] sh, input logic signed [31:0] off);
        longint p;
        p = longint'(acc) * longint'(qm);
        p = p >>> 31;
        p = p >>> sh;
        p = p + longint'(off);
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return 32'(p);
    endfunction

    // Parameter memory (1-cycle read latency, garbage when not read) and requant datapath.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (p_rd[g]) begin
                p_qmul[g]   <= mem_qmul[g][p_addr[g]];
                p_shift[g]  <= mem_shift[g][p_addr[g]];
                p_offset[g] <= mem_offset[g][p_addr[g]];
            end else begin
                p_qmul[g]   <= $urandom;
                p_shift[g]  <= 4'($urandom);
                p_offset[g] <= $urandom;
            end
            if (q_load[g]) begin
                cfg_qmul[g]  <= q_qmul[g];
                cfg_shift[g] <= q_shift[g];
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            q_out[g] = requant(q_acc[g], cfg_qmul[g], cfg_shift[g], q_offset[g]);
        end
    end

    logic signed [31:0] acc_vals [$];
    logic [7:0] got_data [$];
    logic [1:0] got_ch [$];
    logic       got_last [$];
    int         prd_t [$];
    logic [1:0] prd_a [$];
    int         qld_t [$];
    logic [31:0] qld_qm [$];
    logic [3:0]  qld_sh [$];
    logic [31:0] qld_of [$];
    int done_cnt, done_t, last_hs_t, bp_err, rdy_err, stage_err, busy_err, stream_bad;
    bit run_fin;

    task automatic randomize_run(input int i, input int nch, input int npix);
        for (int c = 0; c < nch; c++) begin
            mem_qmul[i][c]   = 32'($urandom_range(32'h1000_0000, 32'h7fff_ffff));
            mem_shift[i][c]  = 4'($urandom_range(0, 3));
            mem_offset[i][c] = 32'($urandom_range(0, 40)) - 32'd20;
        end
        acc_vals.delete();
        for (int k = 0; k < nch * npix; k++) acc_vals.push_back(32'($urandom_range(0, 1200)) - 32'd600);
    endtask

    // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random. vmode: 0 valid held high, 1 random gaps.
    task automatic run_layer(input int i, input int nch, input int npix, input int rmode,
                             input int vmode, input bit extra_start);
        int n, k, t, tr, acc_n, out_n;
        logic pv, pr, pl;
        logic [7:0] pd;
        logic [1:0] pc;
        logic [31:0] e;
        n = nch * npix;
        got_data.delete(); got_ch.delete(); got_last.delete();
        prd_t.delete(); prd_a.delete(); qld_t.delete(); qld_qm.delete(); qld_sh.delete(); qld_of.delete();
        done_cnt = 0; done_t = -10; last_hs_t = -10;
        bp_err = 0; rdy_err = 0; stage_err = 0; busy_err = 0; run_fin = 0;
        k = 0; t = 0; tr = 0; acc_n = 0; out_n = 0;
        pv = 0; pr = 0; pl = 0; pd = '0; pc = '0;
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        fork
            begin
                acc_valid[i] = 1'b0;
                while (k < n && !run_fin) begin
                    if (!acc_valid[i]) acc_valid[i] = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    acc_data[i] = acc_vals[k];
                    @(negedge clk);
                    if (acc_valid[i] && acc_ready[i]) begin
                        k++;
                        @(posedge clk); #1 acc_valid[i] = 1'b0;
                    end else begin
                        @(posedge clk); #1;
                    end
                end
                acc_valid[i] = 1'b0;
            end
            begin
                while (!run_fin) begin
                    case (rmode)
                        0:       out_ready[i] = 1'b1;
                        1:       out_ready[i] = (tr % 4 == 0) || (tr % 4 == 3);
                        default: out_ready[i] = 1'($urandom_range(0, 1));
                    endcase
                    tr++;
                    @(posedge clk); #1;
                end
                out_ready[i] = 1'b1;
            end
            begin
                while (!run_fin) begin
                    @(negedge clk);
                    if (pv && !pr && (!out_valid[i] || out_data[i] !== pd || out_ch[i] !== pc || out_last[i] !== pl))
                        bp_err++;
                    if (out_valid[i] && !out_ready[i] && (acc_n - out_n) > 1 && acc_ready[i]) rdy_err++;
                    if (p_rd[i]) begin prd_t.push_back(t); prd_a.push_back(p_addr[i]); end
                    if (q_load[i]) begin
                        qld_t.push_back(t); qld_qm.push_back(q_qmul[i]);
                        qld_sh.push_back(q_shift[i]); qld_of.push_back(q_offset[i]);
                        if (acc_n - out_n - int'(out_valid[i]) != 0) stage_err++;
                    end
                    if (!busy[i] && done_cnt == 0) busy_err++;
                    if (acc_valid[i] && acc_ready[i]) acc_n++;
                    if (out_valid[i] && out_ready[i]) begin
                        got_data.push_back(out_data[i]); got_ch.push_back(out_ch[i]);
                        got_last.push_back(out_last[i]); out_n++; last_hs_t = t;
                    end
                    if (done[i]) begin done_cnt++; done_t = t; end
                    pv = out_valid[i]; pr = out_ready[i]; pd = out_data[i]; pc = out_ch[i]; pl = out_last[i];
                    t++;
                    if ((done_cnt > 0 && t > done_t + 4) || t > 800) run_fin = 1;
                end
            end
            begin
                if (extra_start) begin
                    repeat (12) @(posedge clk);
                    #1 start[i] = 1'b1;
                    @(posedge clk); #1 start[i] = 1'b0;
                end
            end
        join
        stream_bad = (got_data.size() != n) ? 1 : 0;
        for (int j = 0; j < n && j < got_data.size(); j++) begin
            e = requant(acc_vals[j], mem_qmul[i][j / npix], mem_shift[i][j / npix], mem_offset[i][j / npix]);
            if (got_data[j] !== e[7:0] || got_ch[j] !== 2'(j / npix) || got_last[j] !== (j == n - 1))
                stream_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; acc_valid[i] = 1'b1; acc_data[i] = 32'h1234; out_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({busy[i], done[i], p_rd[i], q_load[i], acc_ready[i], out_valid[i], out_last[i]} !== 7'b0) begin
                fails++;
                $display("FAIL reset_ctrl[%0d]: got %b expected 0", i,
                         {busy[i], done[i], p_rd[i], q_load[i], acc_ready[i], out_valid[i], out_last[i]});
            end
            tests++;
            if ({p_addr[i], q_qmul[i], q_shift[i], q_offset[i], q_acc[i], out_data[i], out_ch[i]} !== '0) begin
                fails++;
                $display("FAIL reset_data[%0d]: got nonzero expected 0", i);
            end
        end
        for (int i = 0; i < 2; i++) acc_valid[i] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_channel();
        logic [7:0] exp_d [4];
        exp_d = '{8'd47, 8'hFD, 8'h80, 8'h7F};
        mem_qmul[0][0] = 32'h4000_0000; mem_shift[0][0] = 4'd1; mem_offset[0][0] = 32'hFFFF_FFFD;
        acc_vals.delete();
        acc_vals.push_back(32'sd200); acc_vals.push_back(32'sd0);
        acc_vals.push_back(-32'sd1000); acc_vals.push_back(32'sd10000);
        run_layer(0, 1, 4, 0, 0, 0);
        tests++;
        if (got_data.size() != 4) begin
            fails++; $display("FAIL single_count: got %0d expected 4", got_data.size());
        end
        for (int j = 0; j < 4 && j < got_data.size(); j++) begin
            tests++;
            if (got_data[j] !== exp_d[j] || got_last[j] !== (j == 3) || got_ch[j] !== 2'd0) begin
                fails++;
                $display("FAIL single_out[%0d]: got data %0d last %0d expected data %0d last %0d",
                         j, $signed(got_data[j]), got_last[j], $signed(exp_d[j]), (j == 3));
            end
        end
        tests++;
        if (done_cnt != 1 || done_t != last_hs_t + 1) begin
            fails++; $display("FAIL single_done: got count %0d at %0d expected 1 at %0d", done_cnt, done_t, last_hs_t + 1);
        end
        tests++;
        if (busy_err != 0) begin fails++; $display("FAIL single_busy: got %0d drops expected 0", busy_err); end
    endtask

    task automatic test_param_seq();
        randomize_run(1, 3, 5);
        run_layer(1, 3, 5, 0, 1, 0);
        tests++;
        if (prd_t.size() != 3 || qld_t.size() != 3) begin
            fails++; $display("FAIL param_counts: got p_rd %0d q_load %0d expected 3 3", prd_t.size(), qld_t.size());
        end
        for (int c = 0; c < 3 && c < prd_t.size() && c < qld_t.size(); c++) begin
            tests++;
            if (prd_a[c] !== 2'(c) || (c > 0 && prd_t[c] <= prd_t[c-1] + 1)) begin
                fails++; $display("FAIL param_addr[%0d]: got %0d expected %0d", c, prd_a[c], c);
            end
            tests++;
            if (qld_t[c] != prd_t[c] + 2) begin
                fails++; $display("FAIL param_qload_time[%0d]: got %0d expected %0d", c, qld_t[c], prd_t[c] + 2);
            end
            tests++;
            if (qld_qm[c] !== mem_qmul[1][c] || qld_sh[c] !== mem_shift[1][c] || qld_of[c] !== mem_offset[1][c]) begin
                fails++; $display("FAIL param_values[%0d]: got %h/%0d/%h expected %h/%0d/%h", c, qld_qm[c], qld_sh[c],
                                  qld_of[c], mem_qmul[1][c], mem_shift[1][c], mem_offset[1][c]);
            end
        end
        tests++;
        if (stream_bad != 0) begin fails++; $display("FAIL param_stream: got %0d bad expected 0", stream_bad); end
    endtask

    task automatic test_drain();
        randomize_run(1, 3, 5);
        run_layer(1, 3, 5, 0, 0, 0);
        tests++;
        if (stage_err != 0) begin fails++; $display("FAIL drain_qload_stage: got %0d expected 0", stage_err); end
        tests++;
        if (stream_bad != 0) begin fails++; $display("FAIL drain_stream: got %0d bad expected 0", stream_bad); end
        tests++;
        if (done_cnt != 1 || done_t != last_hs_t + 1) begin
            fails++; $display("FAIL drain_done: got %0d at %0d expected 1 at %0d", done_cnt, done_t, last_hs_t + 1);
        end
    endtask

    task automatic test_backpressure();
        randomize_run(1, 3, 5);
        run_layer(1, 3, 5, 1, 0, 0);
        tests++;
        if (bp_err != 0) begin fails++; $display("FAIL bp_hold: got %0d changes expected 0", bp_err); end
        tests++;
        if (rdy_err != 0) begin fails++; $display("FAIL bp_acc_ready: got %0d expected 0", rdy_err); end
        tests++;
        if (got_data.size() != 15 || stream_bad != 0) begin
            fails++; $display("FAIL bp_stream: got %0d samples %0d bad expected 15 0", got_data.size(), stream_bad);
        end
    endtask

    task automatic test_reset_midrun();
        int cnt, w;
        randomize_run(1, 3, 5);
        cnt = 0; w = 0;
        out_ready[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0; acc_valid[1] = 1'b1; acc_data[1] = acc_vals[0];
        while (cnt < 2 && w < 40) begin
            @(negedge clk);
            if (acc_valid[1] && acc_ready[1]) cnt++;
            w++;
            if (cnt < 2) begin @(posedge clk); #1 acc_data[1] = acc_vals[cnt]; end
        end
        tests++;
        if (cnt != 2) begin fails++; $display("FAIL midrun_reach: got %0d accepts expected 2", cnt); end
        @(posedge clk); #1;
        tests++;
        if (busy[1] !== 1'b1 || out_valid[1] !== 1'b1) begin
            fails++; $display("FAIL midrun_pre: got busy %b out_valid %b expected 1 1", busy[1], out_valid[1]);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (busy[1] !== 1'b0 || out_valid[1] !== 1'b0 || acc_ready[1] !== 1'b0) begin
            fails++; $display("FAIL midrun_reset: got busy %b out_valid %b acc_ready %b expected 0 0 0",
                              busy[1], out_valid[1], acc_ready[1]);
        end
        @(posedge clk); #1 rst = 1'b0; acc_valid[1] = 1'b0;
        run_layer(1, 3, 5, 0, 1, 0);
        tests++;
        if (prd_t.size() < 1 || prd_t[0] != 0 || prd_a[0] !== 2'd0) begin
            fails++; $display("FAIL midrun_restart: got %0d fetches expected first addr 0 at cycle 0", prd_t.size());
        end
        tests++;
        if (stream_bad != 0) begin fails++; $display("FAIL midrun_stream: got %0d bad expected 0", stream_bad); end
    endtask

    task automatic test_ignored_start();
        randomize_run(1, 3, 5);
        run_layer(1, 3, 5, 0, 1, 1);
        tests++;
        if (prd_t.size() != 3 || prd_a[0] !== 2'd0 || prd_a[1] !== 2'd1 || prd_a[2] !== 2'd2) begin
            fails++; $display("FAIL ignstart_fetch: got %0d fetches expected 3 in order", prd_t.size());
        end
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL ignstart_done: got %0d expected 1", done_cnt); end
        tests++;
        if (stream_bad != 0) begin fails++; $display("FAIL ignstart_stream: got %0d bad expected 0", stream_bad); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int i, nch, npix;
            i = r % 2;
            nch = (i == 0) ? 1 : 3;
            npix = (i == 0) ? 4 : 5;
            randomize_run(i, nch, npix);
            run_layer(i, nch, npix, 2, 1, 0);
            tests++;
            if (stream_bad != 0 || bp_err != 0 || rdy_err != 0) begin
                fails++; $display("FAIL random[%0d]: got bad %0d hold %0d ready %0d expected 0 0 0",
                                  r, stream_bad, bp_err, rdy_err);
            end
            tests++;
            if (done_cnt != 1 || done_t != last_hs_t + 1 || stage_err != 0) begin
                fails++; $display("FAIL random_done[%0d]: got %0d at %0d expected 1 at %0d", r, done_cnt, done_t, last_hs_t + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_param_seq();
        test_drain();
        test_backpressure();
        test_reset_midrun();
        test_ignored_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/quant_ctrl.md
Name: quant_ctrl

Overview:
- Per-output-channel sequencer for the requantization datapath.
- For each channel: fetches qmul/shift/offset from the parameter memory, loads them into the requant datapath, then streams that channel's accumulators through it to an int8 output stream.
- Sits between the conv accumulator array and the activation write-back buffer. Owns when requant configuration may change.

Parameters:
- NCH, 16: output channels per layer run.
- NPIX, 1024: accumulators per channel.
- CW, 4: channel index / param address width; must satisfy 2^CW >= NCH.
- PW, 10: pixel counter width; must satisfy 2^PW >= NPIX.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a layer run when idle
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after last output handshake
- p_rd  out  1  param memory read strobe
- p_addr  out  CW  param memory address = channel index
- p_qmul  in  32  param data, valid 1 cycle after p_rd
- p_shift  in  4  param data, valid 1 cycle after p_rd
- p_offset  in  32  param data, valid 1 cycle after p_rd
- q_load  out  1  one-cycle load enable to the requant config registers
- q_qmul  out  32  config value presented with q_load
- q_shift  out  4  config value presented with q_load
- q_offset  out  32  offset, held stable for the whole channel
- q_acc  out  32  accumulator to requant datapath (registered stage)
- q_out  in  32  requant result, combinational from q_acc
- acc_valid  in  1  accumulator stream valid
- acc_ready  out  1  accumulator stream ready
- acc_data  in  32  signed accumulator
- out_valid  out  1  output stream valid
- out_ready  in  1  output stream ready
- out_data  out  8  q_out[7:0], already clamped to [-128,127]
- out_ch  out  CW  channel of out_data
- out_last  out  1  marks the last pixel of the last channel

Behaviour:
- Reset (async, immediate) forces all of the following regardless of state, including mid-run:
  - State IDLE.
  - busy, done, p_rd, q_load, acc_ready, out_valid, out_last = 0.
  - p_addr, q_qmul, q_shift, q_offset, q_acc, out_data, out_ch = 0.
  - Channel and pixel counters = 0.
- States:
  - IDLE: start -> FETCH with ch=0, busy=1. start is ignored outside IDLE.
  - FETCH: p_rd=1, p_addr=ch for exactly one cycle -> WAIT.
  - WAIT: capture p_qmul/p_shift/p_offset into q_qmul/q_shift/q_offset -> LOAD.
  - LOAD: q_load=1 for one cycle; pix=0 -> RUN.
  - RUN:
    - acc_ready = (pix < NPIX) and (stage empty, or stage emptying this cycle).
    - On acc_valid & acc_ready: q_acc <= acc_data, stage valid set, pix++.
    - When the NPIX-th accumulator is accepted -> DRAIN.
  - DRAIN: acc_ready=0. Wait until stage empty; then either ch++ -> FETCH, or, if ch==NCH-1, -> FIN.
  - FIN: wait for the output register to empty; then done=1 for one cycle, busy=0 -> IDLE.
- Output register:
  - Loads when stage valid & (!out_valid | out_ready).
  - Loads out_data=q_out[7:0], out_ch=ch, and out_last=(last pixel & last channel); stage clears.
  - out_valid drops on out_ready with no new load.
- Latency: 1 cycle from accumulator acceptance to out_valid, given no backpressure. Throughput is 1 pixel/cycle within a channel.
- Channel switch overhead: DRAIN + FETCH + WAIT + LOAD.
- q_qmul/q_shift/q_offset never change while the stage holds data. Config for channel c+1 is loaded only after every channel-c accumulator has left the stage.
- Backpressure: out_ready=0 holds out_data, out_ch, out_last, and the stage contents stable; acc_ready falls within the same cycle.
- acc_valid high outside RUN is not accepted; data is held upstream.
- NPIX=1 and NCH=1 are legal; no counter wrap occurs at a power-of-two NPIX.

Test Plan:
- Single channel end to end:
  - Stimulus: NCH=1, NPIX=4, param qmul=0x40000000, shift=1, offset=-3; acc stream 200, 0, -1000, 10000, with the requant datapath attached.
  - Required: out_data 47, -3, -128, 127 in order; out_last only on the 4th; done 1 cycle after the 4th handshake.
- Param sequencing:
  - Stimulus: NCH=3.
  - Required: p_addr 0, 1, 2 each with a single-cycle p_rd; q_load exactly 3 times, each exactly 2 cycles after its p_rd, with q_qmul/q_shift/q_offset equal to the memory contents.
- Drain ordering:
  - Stimulus: hold acc_valid=1 continuously across a channel boundary.
  - Required: no q_load while the stage is valid; out_ch switches 0->1 only after the NPIX-th channel-0 output.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1 during RUN.
  - Required: out_data stable while out_ready=0; acc_ready=0 while the stage is full and blocked; no samples lost or duplicated (count == NCH*NPIX).
- Reset mid-run:
  - Stimulus: assert rst during RUN with pix=2.
  - Required: same-cycle busy=0 and out_valid=0; after release, start reruns from ch=0, p_addr=0.
- Ignored start:
  - Stimulus: pulse start while busy.
  - Required: no restart; channel sequence unchanged; exactly one done.
